// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus bundle.
// Purpose: groups the ALU request, memory-return handshake, register-file
//          write port and occupancy signals of regfile_wb_arbiter.
// Ports (signals):
//   ALU side : AluValid, AluWaddr[3:0], AluData[15:0], AluStFlag -> ; <- AluStall
//   Mem side : MemValid, MemWaddr[3:0], MemData[15:0] -> ; <- MemReady
//   RF side  : <- WriteEn, Waddr[3:0], WrData[15:0], StFlag
//   Status   : <- Pending[1:0]
// Modports: master = requester/observer side, slave = arbiter side.
interface regfile_wb_arbiter_if;
  logic        AluValid;
  logic [3:0]  AluWaddr;
  logic [15:0] AluData;
  logic        AluStFlag;
  logic        AluStall;
  logic        MemValid;
  logic        MemReady;
  logic [3:0]  MemWaddr;
  logic [15:0] MemData;
  logic        WriteEn;
  logic [3:0]  Waddr;
  logic [15:0] WrData;
  logic        StFlag;
  logic [1:0]  Pending;

  modport master (
    output AluValid, AluWaddr, AluData, AluStFlag,
    output MemValid, MemWaddr, MemData,
    input  AluStall, MemReady,
    input  WriteEn, Waddr, WrData, StFlag, Pending
  );

  modport slave (
    input  AluValid, AluWaddr, AluData, AluStFlag,
    input  MemValid, MemWaddr, MemData,
    output AluStall, MemReady,
    output WriteEn, Waddr, WrData, StFlag, Pending
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Purpose: merges ALU results and memory load returns onto one register-file
//          write port. Memory returns that lose arbitration wait in a small
//          FIFO; a starvation counter and a read-after-write hazard check keep
//          buffered loads from being overtaken indefinitely or out of order.
// Ports:
//   Clk      - clock, all state on posedge
//   Reset_n  - asynchronous active-low reset
//   bus      - regfile_wb_arbiter_if.slave (ALU request, mem handshake,
//              registered RF write port, Pending occupancy)
module regfile_wb_arbiter #(
  parameter int unsigned QDEPTH     = 2,
  parameter int unsigned STARVE_LIM = 3
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  regfile_wb_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned SC_W  = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

  // Buffer storage and bookkeeping
  logic [3:0]       r_buf_addr [QDEPTH];
  logic [15:0]      r_buf_data [QDEPTH];
  logic [QDEPTH-1:0] r_valid;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [SC_W-1:0]  r_starve;

  // Registered write port
  logic        r_we;
  logic [3:0]  r_waddr;
  logic [15:0] r_wdata;
  logic        r_stf;

  logic        w_mem_ready;
  logic        w_mem_acc;
  logic        w_hazard;
  logic        w_alu_stall;
  logic        w_alu_win;
  logic        w_pop;
  logic        w_bypass;
  logic        w_push;
  logic        w_buf_empty;
  logic        w_we_nxt;
  logic [3:0]  w_waddr_nxt;
  logic [15:0] w_wdata_nxt;
  logic        w_stf_nxt;

  assign w_buf_empty = (r_count == '0);
  // Ready comes from registered occupancy only, so a full buffer stays
  // not-ready even on a cycle where it pops.
  assign w_mem_ready = (r_count < CNT_W'(QDEPTH));
  assign w_mem_acc   = bus.MemValid & w_mem_ready;

  // ALU may not overtake a buffered load to the same register.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (r_valid[i] && (r_buf_addr[i] == bus.AluWaddr)) w_hazard = 1'b1;
    end
  end

  assign w_alu_stall = bus.AluValid & ((r_starve == SC_W'(STARVE_LIM)) | w_hazard);
  assign w_alu_win   = bus.AluValid & ~w_alu_stall;
  assign w_pop       = ~w_alu_win & ~w_buf_empty;
  assign w_bypass    = ~w_alu_win & w_buf_empty & w_mem_acc;
  assign w_push      = w_mem_acc & ~w_bypass;

  // Winner select; with no winner the address/data hold.
  always_comb begin
    w_we_nxt    = 1'b0;
    w_waddr_nxt = r_waddr;
    w_wdata_nxt = r_wdata;
    w_stf_nxt   = 1'b0;
    if (w_alu_win) begin
      w_we_nxt    = 1'b1;
      w_waddr_nxt = bus.AluWaddr;
      w_wdata_nxt = bus.AluData;
      w_stf_nxt   = bus.AluStFlag;
    end else if (w_pop) begin
      w_we_nxt    = 1'b1;
      w_waddr_nxt = r_buf_addr[r_rd_ptr];
      w_wdata_nxt = r_buf_data[r_rd_ptr];
    end else if (w_bypass) begin
      w_we_nxt    = 1'b1;
      w_waddr_nxt = bus.MemWaddr;
      w_wdata_nxt = bus.MemData;
    end
  end

  // Output register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_stf   <= 1'b0;
    end else begin
      r_we    <= w_we_nxt;
      r_waddr <= w_waddr_nxt;
      r_wdata <= w_wdata_nxt;
      r_stf   <= w_stf_nxt;
    end
  end

  // FIFO payload storage; validity is tracked separately so no reset needed.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_buf_addr[r_wr_ptr] <= bus.MemWaddr;
      r_buf_data[r_wr_ptr] <= bus.MemData;
    end
  end

  // FIFO pointers, occupancy and per-entry valid bits
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr <= (r_wr_ptr == PTR_W'(QDEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr <= (r_rd_ptr == PTR_W'(QDEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Starvation counter: counts ALU wins made while loads are waiting.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_starve <= '0;
    end else if (w_pop || w_buf_empty) begin
      r_starve <= '0;
    end else if (w_alu_win && (r_starve != SC_W'(STARVE_LIM))) begin
      r_starve <= r_starve + SC_W'(1);
    end
  end

  assign bus.AluStall = w_alu_stall;
  assign bus.MemReady = w_mem_ready;
  assign bus.WriteEn  = r_we;
  assign bus.Waddr    = r_waddr;
  assign bus.WrData   = r_wdata;
  assign bus.StFlag   = r_stf;
  assign bus.Pending  = 2'(r_count);

endmodule
